ddr_arb: RTL
============

# ddr_arb

Round-robin arbiter that shares one 64-bit Avalon-MM DDR port among NCH client channels, each able to issue read or write bursts. It sits between the DDR bridge and the core/video/audio clients. Each client posts a request with a toggle handshake; the arbiter grants one channel at a time, runs the full burst, then toggles that channel's acknowledge. Read data is broadcast on a shared bus with per-channel strobes.

## Interface
- NCH, 3, number of client channels (2..8)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ram_waitrequest  in  1  Avalon stall
- ram_burstcnt  out  8  burst length of current command
- ram_addr  out  29  64-bit word address
- ram_readdata  in  64  read beat data
- ram_read_ready  in  1  read beat valid
- ram_read  out  1  read command
- ram_writedata  out  64  write beat data
- ram_byteenable  out  8  write byte enables (8'hFF for reads)
- ram_write  out  1  write command/beat
- ch_addr  in  NCH*29  per-channel word address
- ch_burst  in  NCH*8  per-channel burst length; 0 treated as 1
- ch_we  in  NCH  1 = write request, 0 = read
- ch_wdata  in  NCH*64  per-channel current write beat
- ch_be  in  NCH*8  per-channel byte enables
- ch_req  in  NCH  request toggle; pending when ch_req[i] != ch_ack[i]
- ch_ack  out  NCH  acknowledge toggle; flips when burst complete
- ch_wnext  out  NCH  combinational: write beat of channel i accepted this cycle
- ch_rdata  out  64  shared registered read data
- ch_rvalid  out  NCH  one-cycle strobe: ch_rdata valid for channel i

## Operation
- States: IDLE, RCMD, RDATA, WR.
- IDLE: pending vector = ch_req ^ ch_ack. If nonzero, grant first pending channel searching upward (wrapping) from last_grant+1. Latch grant, addr, burst (0→1), we. Next state RCMD (ram_read=1) or WR (ram_write=1). last_grant ← grant.
- RCMD: hold ram_read, ram_addr, ram_burstcnt until ram_waitrequest=0; then drop ram_read, beat counter ← 0, go RDATA.
- RDATA: each ram_read_ready: ch_rdata ← ram_readdata, ch_rvalid[grant] ← 1, counter+1. On the last beat, ch_ack[grant] flips in the same edge; go IDLE.
- WR: ram_writedata/ram_byteenable = ch_wdata/ch_be of grant (combinational mux); ram_addr/ram_burstcnt held whole burst. Beat accepted when ram_write & !ram_waitrequest; ch_wnext[grant]=1 that cycle; client presents next beat on following cycle. After last beat: ram_write←0, ch_ack flips, go IDLE.
- Requests arriving during a burst wait; a channel re-toggling ch_req before its ack is a client error (ignored).
- ram_read_ready outside RDATA is dropped (no rvalid).
- Beat counter 8 bits; burst of 255 completes without overflow.

## Timing
- Reset values: ram_read=0, ram_write=0, ram_burstcnt=0, ram_addr=0, ram_byteenable=8'hFF, ch_ack=0, ch_rvalid=0, ch_rdata=0, state=IDLE, last_grant=NCH-1 (ch0 first priority).
- Request visible in IDLE at edge N → command asserted from edge N+1.
- Min one IDLE cycle between transactions; ack flip to next command ≥2 cycles.
- Write burst of B beats with no stall: ram_write high exactly B cycles.
- Reset mid-burst: immediately returns to reset values; clients must clear ch_req with the same reset; DDR must be idle before reset release.
- Simultaneous pending on all channels: strict rotation, each granted once per NCH transactions.

## Structure
- Package ddr_arb_pkg: state enum, ADDR_W=29, DATA_W=64, BURST_W=8.
- Sub-module ddr_arb_rr: combinational round-robin picker (pending, last_grant → grant, any).

## Test plan
- Single read ch1, addr 29'h100, burst 4, readdata 1..4 → ram_read held through 2 waitrequest cycles, four ch_rvalid[1] with data 1..4, ch_ack[1] flips on 4th beat.
- Single write ch0, burst 3, waitrequest high on beat 2 → ram_write 4 cycles, ch_wnext[0] 3 pulses, DDR sees wdata 3 beats in order, ack flips.
- All three channels toggle same cycle, then re-toggle on each ack → grant order 0,1,2,0,1,2.
- Burst=0 read → exactly one beat issued (ram_burstcnt=1), ack flips after it.
- Reset asserted in mid-RDATA → next cycle all outputs at reset values, stray ram_read_ready produces no rvalid.
- Write burst 255 no stall → 255 wnext pulses, ack flips once.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared types and widths for the DDR port arbiter.
package ddr_arb_pkg;

  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;
  localparam int BE_W    = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RCMD  = 2'd1,
    ST_RDATA = 2'd2,
    ST_WR    = 2'd3
  } arb_state_e;

  // A zero-length request still moves one beat.
  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] b);
    return (b == '0) ? BURST_W'(1) : b;
  endfunction

endpackage

// File: rtl/ddr_arb_rr.sv
// Combinational round-robin picker: first pending channel above last_grant, wrapping.
module ddr_arb_rr
  import ddr_arb_pkg::*;
#(
  parameter int NCH = 3,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] pending,
  input  logic [IW-1:0]  last_grant,
  output logic [IW-1:0]  grant,
  output logic           any
);

  logic [IW-1:0] idx;

  // Scan downward so the lowest offset from last_grant is assigned last and wins.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NCH; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NCH);
      if (pending[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_arb.sv
// Round-robin arbiter sharing one Avalon-MM DDR port among NCH toggle-handshake clients.
// Handshake: channel i is pending while ch_req[i] != ch_ack[i]; ch_ack[i] flips once its whole burst is done.
module ddr_arb
  import ddr_arb_pkg::*;
#(
  parameter int NCH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ram_waitrequest,
  output logic [BURST_W-1:0]      ram_burstcnt,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [DATA_W-1:0]       ram_readdata,
  input  logic                    ram_read_ready,
  output logic                    ram_read,
  output logic [DATA_W-1:0]       ram_writedata,
  output logic [BE_W-1:0]         ram_byteenable,
  output logic                    ram_write,
  input  logic [NCH*ADDR_W-1:0]   ch_addr,
  input  logic [NCH*BURST_W-1:0]  ch_burst,
  input  logic [NCH-1:0]          ch_we,
  input  logic [NCH*DATA_W-1:0]   ch_wdata,
  input  logic [NCH*BE_W-1:0]     ch_be,
  input  logic [NCH-1:0]          ch_req,
  output logic [NCH-1:0]          ch_ack,
  output logic [NCH-1:0]          ch_wnext,
  output logic [DATA_W-1:0]       ch_rdata,
  output logic [NCH-1:0]          ch_rvalid,
  output arb_state_e              dbg_state
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 we_q, we_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]       ack_q, ack_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [NCH-1:0]       rvalid_q, rvalid_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic                 settled_q, settled_d;

  logic [NCH-1:0]       pending;
  logic [IW-1:0]        pick;
  logic                 pick_any;
  logic                 start;
  logic                 wr_accept;
  logic                 last_beat;

  assign pending   = ch_req ^ ack_q;
  // settled_q guarantees a full IDLE cycle before a grant, spacing ack and next command.
  assign start     = (state_q == ST_IDLE) && settled_q && pick_any;
  assign wr_accept = (state_q == ST_WR) && write_q && !ram_waitrequest;
  assign last_beat = (cnt_q == (burst_q - BURST_W'(1)));

  ddr_arb_rr #(.NCH(NCH), .IW(IW)) u_rr (
    .pending    (pending),
    .last_grant (last_grant_q),
    .grant      (pick),
    .any        (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= IW'(NCH - 1);
      addr_q       <= '0;
      burst_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      settled_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      burst_q      <= burst_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      read_q       <= read_d;
      write_q      <= write_d;
      settled_q    <= settled_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ch_we[pick] ? ST_WR : ST_RCMD;
      ST_RCMD:  if (!ram_waitrequest) state_d = ST_RDATA;
      ST_RDATA: if (ram_read_ready && last_beat) state_d = ST_IDLE;
      ST_WR:    if (wr_accept && last_beat) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    burst_d      = burst_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    ack_d        = ack_q;
    rdata_d      = rdata_q;
    rvalid_d     = '0;
    read_d       = read_q;
    write_d      = write_q;
    settled_d    = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          grant_d      = pick;
          last_grant_d = pick;
          addr_d       = ch_addr[int'(pick)*ADDR_W +: ADDR_W];
          burst_d      = eff_burst(ch_burst[int'(pick)*BURST_W +: BURST_W]);
          we_d         = ch_we[pick];
          cnt_d        = '0;
          read_d       = !ch_we[pick];
          write_d      = ch_we[pick];
        end
      end
      ST_RCMD: begin
        if (!ram_waitrequest) begin
          read_d = 1'b0;
          cnt_d  = '0;
        end
      end
      ST_RDATA: begin
        if (ram_read_ready) begin
          rdata_d           = ram_readdata;
          rvalid_d[grant_q] = 1'b1;
          cnt_d             = cnt_q + BURST_W'(1);
          if (last_beat) ack_d[grant_q] = ~ack_q[grant_q];
        end
      end
      ST_WR: begin
        if (wr_accept) begin
          cnt_d = cnt_q + BURST_W'(1);
          if (last_beat) begin
            write_d        = 1'b0;
            ack_d[grant_q] = ~ack_q[grant_q];
          end
        end
      end
      default: ;
    endcase
  end

  // Write beat data is steered straight from the granted client.
  always_comb begin
    ch_wnext          = '0;
    ch_wnext[grant_q] = wr_accept;
    ram_writedata     = ch_wdata[int'(grant_q)*DATA_W +: DATA_W];
    ram_byteenable    = (state_q == ST_WR) ? ch_be[int'(grant_q)*BE_W +: BE_W] : '1;
  end

  assign ram_read     = read_q;
  assign ram_write    = write_q;
  assign ram_addr     = addr_q;
  assign ram_burstcnt = burst_q;
  assign ch_ack       = ack_q;
  assign ch_rdata     = rdata_q;
  assign ch_rvalid    = rvalid_q;
  assign dbg_state    = state_q;

endmodule
